// File: rtl/iseq_dispatcher_pkg.sv
// Shared softMC instruction-set definitions: opcode field position and the
// opcodes the dispatcher interprets itself.
package iseq_dispatcher_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;

    typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

    localparam opcode_t OPC_END_ISEQ   = 4'b0000;
    localparam opcode_t OPC_SET_BUSDIR = 4'b0001;
    localparam opcode_t OPC_WAIT       = 4'b0010;

    function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/iseq_dispatcher_if.sv
// Instruction-load and command-issue signals of the sequence dispatcher.
// The master drives writes, the start pulse and downstream back-pressure.
interface iseq_dispatcher_if;
    import iseq_dispatcher_pkg::*;

    logic               instr_fifo_en;
    logic [INSTR_W-1:0] instr_fifo_data;
    logic               process_iseq;
    logic               dispatcher_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic               out_ready;
    logic               busy;
    logic               overflow;

    modport master (
        output instr_fifo_en,
        output instr_fifo_data,
        output process_iseq,
        output out_ready,
        input  dispatcher_ready,
        input  out_valid,
        input  out_instr,
        input  busy,
        input  overflow
    );

    modport slave (
        input  instr_fifo_en,
        input  instr_fifo_data,
        input  process_iseq,
        input  out_ready,
        output dispatcher_ready,
        output out_valid,
        output out_instr,
        output busy,
        output overflow
    );

endinterface

// File: rtl/iseq_fifo.sv
// Instruction buffer: simple dual-port RAM with a registered read port.
// Contents are intentionally not reset.
module iseq_fifo
    import iseq_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [INSTR_W-1:0] i_wr_data,
    input  logic               i_rd_en,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [INSTR_W-1:0] o_rd_data
);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/iseq_dispatcher.sv
// Buffers an instruction sequence in IDLE, then issues it word by word,
// executing WAIT and END_ISEQ locally.
module iseq_dispatcher
    import iseq_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned WAIT_W = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    iseq_dispatcher_if.slave  bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_head;
    logic [ADDR_W-1:0]  r_tail;
    logic [ADDR_W:0]    r_count;
    logic [WAIT_W-1:0]  r_wcnt;
    logic               r_rv;
    logic               r_ov;
    logic [INSTR_W-1:0] r_oi;
    logic               r_ovf;

    logic [INSTR_W-1:0] w_rd_data;
    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_drop;
    logic               w_run;
    logic               w_wait_last;
    logic               w_act;
    logic               w_out_free;
    logic               w_is_wait;
    logic               w_is_end;
    logic               w_adv;
    logic               w_fetch;
    logic               w_drain;
    logic [WAIT_W-1:0]  w_wait_n;

    iseq_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_tail),
        .i_wr_data (bus.instr_fifo_data),
        .i_rd_en   (w_fetch),
        .i_rd_addr (r_head),
        .o_rd_data (w_rd_data)
    );

    // r_rv marks w_rd_data as a fetched, not yet decoded head word. The last
    // WAIT cycle decodes like ISSUE so the gap is exactly the wait count.
    always_comb begin
        w_full      = (r_count == FULL_CNT);
        w_empty     = (r_count == '0);
        w_wr        = bus.instr_fifo_en && (r_state == ST_IDLE) && !w_full;
        w_drop      = bus.instr_fifo_en && !w_wr;
        w_run       = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
        w_wait_last = (r_state == ST_WAIT) && (r_wcnt <= WAIT_W'(1));
        w_act       = (r_state == ST_ISSUE) || w_wait_last;
        w_out_free  = !r_ov || bus.out_ready;
        w_is_wait   = (get_opcode(w_rd_data) == OPC_WAIT);
        w_is_end    = (get_opcode(w_rd_data) == OPC_END_ISEQ);
        w_adv       = w_act && r_rv && w_out_free;
        w_fetch     = w_run && !w_empty && (!r_rv || (w_adv && !w_is_end));
        w_drain     = w_act && !r_rv && w_empty && w_out_free;
        w_wait_n    = (w_rd_data[WAIT_W-1:0] == '0) ? WAIT_W'(1) : w_rd_data[WAIT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_wcnt  <= '0;
            r_rv    <= 1'b0;
            r_ov    <= 1'b0;
            r_oi    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_wr) begin
                        r_tail  <= r_tail + ADDR_W'(1);
                        r_count <= r_count + (ADDR_W+1)'(1);
                    end
                    if (bus.process_iseq && (!w_empty || w_wr)) begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (w_fetch) begin
                        r_head  <= r_head + ADDR_W'(1);
                        r_count <= r_count - (ADDR_W+1)'(1);
                        r_rv    <= 1'b1;
                    end else if (w_adv) begin
                        r_rv    <= 1'b0;
                    end
                    if (w_adv) begin
                        if (w_is_wait) begin
                            r_ov    <= 1'b0;
                            r_wcnt  <= w_wait_n;
                            r_state <= ST_WAIT;
                        end else if (w_is_end) begin
                            r_ov    <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_ov    <= 1'b1;
                            r_oi    <= w_rd_data;
                            r_state <= ST_ISSUE;
                        end
                    end else begin
                        if (bus.out_ready) begin
                            r_ov <= 1'b0;
                        end
                        if (w_drain) begin
                            r_state <= ST_DONE;
                        end else if (w_wait_last) begin
                            r_state <= ST_ISSUE;
                        end else if (r_state == ST_WAIT) begin
                            r_wcnt <= r_wcnt - WAIT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_head  <= '0;
                    r_tail  <= '0;
                    r_count <= '0;
                    r_rv    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dispatcher_ready = (r_state == ST_IDLE) && !w_full;
    assign bus.out_valid        = r_ov;
    assign bus.out_instr        = r_oi;
    assign bus.busy             = (r_state != ST_IDLE);
    assign bus.overflow         = r_ovf;

endmodule

// File: tb/tb_iseq_dispatcher.sv
// Self-checking bench for iseq_dispatcher: scoreboard of issued words plus
// a table of WAIT-gap vectors and hand-written corner-case sequences.
module tb_iseq_dispatcher;
    import iseq_dispatcher_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    iseq_dispatcher_if bus ();

    iseq_dispatcher #(
        .DEPTH  (DEPTH),
        .WAIT_W (28)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          rdy_mode = 1;  // 0: never ready, 1: always, 2: one cycle in three
    logic [31:0] sb_q [$];
    int          acc_q [$];

    typedef struct {
        logic [31:0] a;
        int          n;
        logic [31:0] b;
        int          exp_gap;
    } gap_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic logic [31:0] mk_wait(input int n);
        return {OPC_WAIT, 28'(n)};
    endfunction

    function automatic logic [31:0] mk_end();
        return {OPC_END_ISEQ, 28'h0};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = (cyc % 3 == 0);
            endcase
        end
    end

    // Monitor: scoreboard compare on every accept, hold check on every stall.
    initial begin
        bit          prev_stall;
        logic [31:0] prev_instr;
        prev_stall = 1'b0;
        prev_instr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                    check("hold_instr", bus.out_instr, prev_instr);
                end
                if (bus.out_valid && bus.out_ready) begin
                    acc_q.push_back(cyc);
                    if (sb_q.size() == 0) begin
                        n_total++;
                        $display("FAIL sb_extra: got %h, no word expected", bus.out_instr);
                    end else begin
                        check("sb_word", bus.out_instr, sb_q.pop_front());
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_instr = bus.out_instr;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_overflow", {31'b0, bus.overflow}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'b0, bus.dispatcher_ready}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] w, input bit push);
        bus.instr_fifo_en   = 1'b1;
        bus.instr_fifo_data = w;
        if (push) sb_q.push_back(w);
        @(posedge clk);
        #1 bus.instr_fifo_en = 1'b0;
    endtask

    task automatic pulse(input bit with_wr, input logic [31:0] w);
        bus.process_iseq    = 1'b1;
        bus.instr_fifo_en   = with_wr;
        bus.instr_fifo_data = w;
        @(posedge clk);
        #1;
        bus.process_iseq  = 1'b0;
        bus.instr_fifo_en = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check("done_busy", {31'b0, bus.busy}, 32'd0);
    endtask

    gap_vec_t gap_tbl [4];

    initial begin
        int lat;
        int nvalid;

        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int nvalid;

        gap_tbl[0] = '{a: 32'hA000_0001, n: 5, b: 32'hB000_0001, exp_gap: 5};
        gap_tbl[1] = '{a: 32'hA000_0002, n: 0, b: 32'hB000_0002, exp_gap: 1};
        gap_tbl[2] = '{a: 32'hA000_0003, n: 1, b: 32'hB000_0003, exp_gap: 1};
        gap_tbl[3] = '{a: 32'hA000_0004, n: 3, b: 32'hB000_0004, exp_gap: 3};

        bus.instr_fifo_en   = 1'b0;
        bus.instr_fifo_data = '0;
        bus.process_iseq    = 1'b0;
        rdy_mode            = 1;
        do_reset();

        // A,B,C then END written together with the start pulse.
        wr(32'hC100_000A, 1'b1);
        wr(32'hC100_000B, 1'b1);
        wr(32'hC100_000C, 1'b1);
        acc_q.delete();
        pulse(1'b1, mk_end());
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            lat++;
        end
        check("first_latency", lat, 32'd2);
        wait_done();
        check("abc_accepts", acc_q.size(), 32'd3);
        if (acc_q.size() == 3) check("abc_back2back", acc_q[2] - acc_q[0], 32'd2);
        check("abc_sb_empty", sb_q.size(), 32'd0);
        check("ready_after_done", {31'b0, bus.dispatcher_ready}, 32'd1);

        for (int v = 0; v < 4; v++) begin
            acc_q.delete();
            wr(gap_tbl[v].a, 1'b1);
            wr(mk_wait(gap_tbl[v].n), 1'b0);
            wr(gap_tbl[v].b, 1'b1);
            wr(mk_end(), 1'b0);
            pulse(1'b0, '0);
            wait_done();
            check("gap_accepts", acc_q.size(), 32'd2);
            if (acc_q.size() == 2) check("wait_gap", acc_q[1] - acc_q[0] - 1, gap_tbl[v].exp_gap);
        end

        // Downstream ready one cycle in three.
        rdy_mode = 2;
        for (int i = 0; i < 6; i++) wr(32'hD000_0000 + i, 1'b1);
        wr(mk_end(), 1'b0);
        pulse(1'b0, '0);
        wait_done();
        check("stall_sb_empty", sb_q.size(), 32'd0);

        // Fill to DEPTH, then one dropped word.
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < DEPTH; i++) wr(32'h9000_0000 + i, 1'b1);
        check("full_ready", {31'b0, bus.dispatcher_ready}, 32'd0);
        check("full_no_ovf", {31'b0, bus.overflow}, 32'd0);
        wr(32'hEEEE_0001, 1'b0);
        check("full_ovf", {31'b0, bus.overflow}, 32'd1);
        pulse(1'b0, '0);
        wait_done();
        check("full_sb_empty", sb_q.size(), 32'd0);
        check("ovf_sticky", {31'b0, bus.overflow}, 32'd1);

        // Write while ISSUE is stalled.
        do_reset();
        rdy_mode = 0;
        wr(32'h7000_0001, 1'b1);
        wr(32'h7000_0002, 1'b1);
        wr(32'h7000_0003, 1'b1);
        wr(mk_end(), 1'b0);
        pulse(1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("issue_busy", {31'b0, bus.busy}, 32'd1);
        wr(32'h7000_00FF, 1'b0);
        check("issue_wr_ovf", {31'b0, bus.overflow}, 32'd1);
        rdy_mode = 1;
        wait_done();
        check("issue_sb_empty", sb_q.size(), 32'd0);

        // Reset in the middle of WAIT(100).
        do_reset();
        wr(32'h6000_0001, 1'b1);
        wr(mk_wait(100), 1'b0);
        wr(32'h6000_0002, 1'b1);
        wr(mk_end(), 1'b0);
        pulse(1'b0, '0);
        repeat (15) @(posedge clk);
        #1;
        check("wait_busy", {31'b0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", {31'b0, bus.out_valid}, 32'd0);
        check("abort_instr", bus.out_instr, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_ready", {31'b0, bus.dispatcher_ready}, 32'd1);
        rst_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus.out_valid) nvalid++;
        end
        check("abort_no_valid", nvalid, 32'd0);
        pulse(1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("empty_start_busy", {31'b0, bus.busy}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
